// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state codes, opcodes and ALU operation codes for RV control
package rv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EX_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_WB_ALU   = 4'd5,
    S_WB_LUI   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
endpackage

// File: rtl/alu_op_dec.sv
// alu_op_dec: maps opcode/funct fields to the 4-bit ALU operation code
module alu_op_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);
  // funct7[5] selects SUB/SRA for R-type, but only SRAI among immediates
  assign alu_op = (opcode == OP_R || (opcode == OP_I && funct3 == 3'b101)) ? {funct7_5, funct3} :
                  (opcode == OP_I) ? {1'b0, funct3} : ALU_ADD;
endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle RV control FSM with registered Moore outputs
module mc_ctrl_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int MEM_WAIT = 1,
  parameter int EN_MEM   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                rs2_imm_s,
  output logic [1:0]          w_data_s,
  output logic [1:0]          pc_s,
  output logic                Reg_Write,
  output logic                IR_Write,
  output logic                PC_Write,
  output logic                Mem_Read,
  output logic                Mem_Write,
  output logic                illegal,
  output logic [3:0]          state
);
  state_t st, nxt;
  logic armed, is_ld, mem_done, is_mem, br_ok, unused_f7;
  logic [3:0] dec_op;
  assign state = st;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  assign mem_done = (MEM_WAIT == 0) || mem_ready;
  assign is_mem = (EN_MEM != 0) && (opcode == OP_LOAD || opcode == OP_STORE);
  assign br_ok = funct3[2:1] == 2'b00;
  alu_op_dec u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7[5]),
    .alu_op   (dec_op)
  );
  // next-state selection; IDLE waits one armed cycle so FETCH lands on the second edge
  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:     nxt = armed ? S_FETCH : S_IDLE;
      S_FETCH:    nxt = S_DECODE;
      S_DECODE:   nxt = opcode == OP_R ? S_EX_R :
                        opcode == OP_I ? S_EX_I :
                        opcode == OP_LUI ? S_WB_LUI :
                        is_mem ? S_MEM_ADDR :
                        (opcode == OP_BRANCH && br_ok) ? S_BRANCH :
                        opcode == OP_JAL ? S_JAL : S_TRAP;
      S_EX_R,
      S_EX_I:     nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = mem_done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = mem_done ? S_FETCH : S_MEM_WR;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end
  // state and outputs registered together, outputs describing the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      armed     <= 1'b0;
      is_ld     <= 1'b0;
      ALU_OP    <= '0;
      rs2_imm_s <= 1'b0;
      w_data_s  <= 2'b00;
      pc_s      <= 2'b00;
      Reg_Write <= 1'b0;
      IR_Write  <= 1'b0;
      PC_Write  <= 1'b0;
      Mem_Read  <= 1'b0;
      Mem_Write <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      st        <= nxt;
      armed     <= 1'b1;
      is_ld     <= (st == S_DECODE) ? (opcode == OP_LOAD) : is_ld;
      ALU_OP    <= ALU_OP_W'((nxt == S_EX_R || nxt == S_EX_I) ? dec_op :
                             nxt == S_WB_ALU ? ALU_OP[3:0] :
                             nxt == S_BRANCH ? ALU_SUB : ALU_ADD);
      rs2_imm_s <= nxt == S_EX_I || nxt == S_MEM_ADDR || (nxt == S_WB_ALU && rs2_imm_s);
      w_data_s  <= nxt == S_WB_LUI ? 2'b01 : nxt == S_MEM_WB ? 2'b10 : nxt == S_JAL ? 2'b11 : 2'b00;
      pc_s      <= nxt == S_BRANCH ? 2'b01 : nxt == S_JAL ? 2'b10 : 2'b00;
      Reg_Write <= nxt inside {S_WB_ALU, S_WB_LUI, S_MEM_WB, S_JAL};
      IR_Write  <= nxt == S_FETCH;
      PC_Write  <= nxt == S_FETCH || nxt == S_JAL || (nxt == S_BRANCH && (funct3[0] ? !zero : zero));
      Mem_Read  <= nxt == S_MEM_RD;
      Mem_Write <= nxt == S_MEM_WR;
      illegal   <= illegal || nxt == S_TRAP;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: randomized instruction traces checked against a per-instruction trace model
module tb_mc_ctrl_unit;
  import rv_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] ALU_OP, state;
  logic rs2_imm_s, Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal;
  logic [1:0] w_data_s, pc_s;
  int checks = 0, fails = 0;
  localparam logic [5:0] RW = 6'b100000, IRW = 6'b010000, PCW = 6'b001000;
  localparam logic [5:0] MR = 6'b000100, MW = 6'b000010, ILL = 6'b000001;
  localparam logic [6:0] ADD_OP = 7'b0110011, IMM_OP = 7'b0010011, LUI_OP = 7'b0110111;
  localparam logic [6:0] LD_OP = 7'b0000011, ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
  logic [18:0] obs;
  logic [18:0] exp_q[$], msk_q[$];
  bit rdy_q[$];
  logic [6:0] legal_ops[7] = '{ADD_OP, IMM_OP, LUI_OP, LD_OP, ST_OP, BR_OP, JAL_OP};

  mc_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .ALU_OP(ALU_OP), .rs2_imm_s(rs2_imm_s),
    .w_data_s(w_data_s), .pc_s(pc_s), .Reg_Write(Reg_Write), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;
  assign obs = {state, ALU_OP, rs2_imm_s, w_data_s, pc_s, Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal};

  // one expected cycle: fields a state leaves undefined are masked out
  task automatic push(input logic [3:0] s, input logic [3:0] a, input logic r, input logic [1:0] w,
                      input logic [1:0] p, input logic [5:0] sb, input bit rdy);
    logic [18:0] m;
    m = {4'hf, 4'h0, 1'b0, 2'b00, 2'b00, 6'h3f};
    if (s inside {S_EX_R, S_EX_I, S_WB_ALU, S_MEM_ADDR, S_BRANCH}) m[14:10] = 5'h1f;
    if (s inside {S_WB_ALU, S_WB_LUI, S_MEM_WB, S_JAL}) m[9:8] = 2'b11;
    if (s inside {S_FETCH, S_BRANCH, S_JAL}) m[7:6] = 2'b11;
    exp_q.push_back({s, a, r, w, p, sb});
    msk_q.push_back(m);
    rdy_q.push_back(rdy);
  endtask

  // expected cycle-by-cycle trace of one instruction starting from FETCH
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input bit z, input int w);
    int a;
    exp_q.delete(); msk_q.delete(); rdy_q.delete();
    push(S_DECODE, 4'd0, 1'b0, 2'b00, 2'b00, 6'd0, 1'b0);
    case (op)
      ADD_OP: begin
        a = f3 + (f7[5] ? 8 : 0);
        push(S_EX_R, a[3:0], 1'b0, 2'b00, 2'b00, 6'd0, 1'b0);
        push(S_WB_ALU, a[3:0], 1'b0, 2'b00, 2'b00, RW, 1'b0);
      end
      IMM_OP: begin
        a = f3 + ((f3 == 3'd5 && f7[5]) ? 8 : 0);
        push(S_EX_I, a[3:0], 1'b1, 2'b00, 2'b00, 6'd0, 1'b0);
        push(S_WB_ALU, a[3:0], 1'b1, 2'b00, 2'b00, RW, 1'b0);
      end
      LUI_OP: push(S_WB_LUI, 4'd0, 1'b0, 2'b01, 2'b00, RW, 1'b0);
      LD_OP, ST_OP: begin
        push(S_MEM_ADDR, 4'd0, 1'b1, 2'b00, 2'b00, 6'd0, 1'b0);
        for (int i = 0; i <= w; i++)
          push(op == ST_OP ? S_MEM_WR : S_MEM_RD, 4'd0, 1'b0, 2'b00, 2'b00, op == ST_OP ? MW : MR, 1'b0);
        if (op == LD_OP) push(S_MEM_WB, 4'd0, 1'b0, 2'b10, 2'b00, RW, 1'b1);
      end
      BR_OP: begin
        if (f3 < 3'd2) push(S_BRANCH, 4'd8, 1'b0, 2'b00, 2'b01, ((f3 == 3'd0) ? z : !z) ? PCW : 6'd0, 1'b0);
        else push(S_TRAP, 4'd0, 1'b0, 2'b00, 2'b00, ILL, 1'b0);
      end
      JAL_OP: push(S_JAL, 4'd0, 1'b0, 2'b11, 2'b10, RW | PCW, 1'b0);
      default: push(S_TRAP, 4'd0, 1'b0, 2'b00, 2'b00, ILL, 1'b0);
    endcase
    if (exp_q[exp_q.size()-1][18:15] != S_TRAP)
      push(S_FETCH, 4'd0, 1'b0, 2'b00, 2'b00, IRW | PCW, op == ST_OP);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input bit z);
    opcode = op; funct3 = f3; funct7 = f7; zero = z;
  endtask

  task automatic reset_to_fetch();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'd0) begin fails++; $display("FAIL reset_async: got %h want %h", obs, 19'd0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 19'd0) begin fails++; $display("FAIL reset_first_edge: got %h want %h", obs, 19'd0); end
    @(posedge clk); #1;
    checks++;
    if ({state, pc_s, Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal} !== {S_FETCH, 2'b00, RW ^ RW | IRW | PCW})
      begin fails++; $display("FAIL reset_first_fetch: state %0d strobes %b", state, {Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal}); end
  endtask

  task automatic test_alu();
    for (int n = 0; n < 18; n++) begin
      if (n == 0) set_instr(ADD_OP, 3'b000, 7'b0000000, 1'b0);
      else if (n == 1) set_instr(IMM_OP, 3'b101, 7'b0100000, 1'b0);
      else set_instr($urandom_range(0, 1) ? ADD_OP : IMM_OP, 3'($urandom), 7'($urandom), 1'($urandom));
      model(opcode, funct3, funct7, zero, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = rdy_q[i];
        @(posedge clk); #1;
        checks++;
        if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          begin fails++; $display("FAIL alu op=%b f3=%b step %0d: got %h want %h", opcode, funct3, i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
      end
    end
  endtask

  task automatic test_mem();
    int w;
    for (int n = 0; n < 10; n++) begin
      w = n == 0 ? 3 : n == 1 ? 2 : n == 2 ? 0 : $urandom_range(0, 5);
      set_instr(n == 1 ? ST_OP : n < 3 ? LD_OP : ($urandom_range(0, 1) ? LD_OP : ST_OP), 3'($urandom), 7'($urandom), 1'b0);
      model(opcode, funct3, funct7, zero, w);
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = rdy_q[i];
        @(posedge clk); #1;
        checks++;
        if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          begin fails++; $display("FAIL mem op=%b wait=%0d step %0d: got %h want %h", opcode, w, i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_branch_jal();
    logic [6:0] ops[6] = '{BR_OP, BR_OP, BR_OP, BR_OP, JAL_OP, LUI_OP};
    logic [2:0] f3s[6] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    bit zs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 6; n++) begin
      set_instr(ops[n], f3s[n], 7'($urandom), zs[n]);
      model(opcode, funct3, funct7, zero, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = rdy_q[i];
        @(posedge clk); #1;
        checks++;
        if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          begin fails++; $display("FAIL branch_jal op=%b f3=%b z=%b step %0d: got %h want %h", opcode, funct3, zero, i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    for (int n = 0; n < 25; n++) begin
      k = $urandom_range(0, 6);
      set_instr(legal_ops[k], k == 5 ? 3'($urandom_range(0, 1)) : 3'($urandom), 7'($urandom), 1'($urandom));
      model(opcode, funct3, funct7, zero, $urandom_range(0, 3));
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = rdy_q[i];
        @(posedge clk); #1;
        checks++;
        if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          begin fails++; $display("FAIL b2b op=%b f3=%b step %0d: got %h want %h", opcode, funct3, i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_trap();
    for (int n = 0; n < 2; n++) begin
      if (n == 0) set_instr(7'b1111111, 3'b000, 7'd0, 1'b0);
      else set_instr(BR_OP, 3'b010, 7'd0, 1'b0);
      model(opcode, funct3, funct7, zero, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        mem_ready = rdy_q[i];
        @(posedge clk); #1;
        checks++;
        if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          begin fails++; $display("FAIL trap_entry op=%b f3=%b step %0d: got %h want %h", opcode, funct3, i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
      end
      for (int c = 0; c < 20; c++) begin
        set_instr(legal_ops[$urandom_range(0, 6)], 3'($urandom), 7'($urandom), 1'($urandom));
        mem_ready = 1'($urandom);
        @(posedge clk); #1;
        checks++;
        if ({state, Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal} !== {S_TRAP, ILL})
          begin fails++; $display("FAIL trap_hold cycle %0d: state %0d illegal %b", c, state, illegal); end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 19'd0) begin fails++; $display("FAIL trap_reset: got %h want %h", obs, 19'd0); end
      reset_to_fetch();
    end
  endtask

  task automatic test_reset_mid_mem();
    set_instr(ST_OP, 3'b010, 7'd0, 1'b0);
    model(opcode, funct3, funct7, zero, 10);
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy_q[i];
      @(posedge clk); #1;
      checks++;
      if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
        begin fails++; $display("FAIL memwr_pre step %0d: got %h want %h", i, obs & msk_q[i], exp_q[i] & msk_q[i]); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, Mem_Write, obs} !== {S_IDLE, 1'b0, 19'd0})
      begin fails++; $display("FAIL memwr_reset: state %0d Mem_Write %b obs %h", state, Mem_Write, obs); end
    reset_to_fetch();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch_jal();
    test_back_to_back();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
